axil_test_device: RTL and testbench
===================================

// Module: axil_test_device
// PURPOSE
//  AXI4-Lite slave test device on the CPU-side AXI-Lite bus, directly downstream of the
//  Wishbone-to-AXI-Lite bridge. Exposes ID/version, control, transaction statistics,
//  a 64-bit cycle counter and scratch registers, so firmware can exercise the bridge end to end.
//  Up to one transaction is outstanding per channel; writes and reads proceed independently.
// PARAMETERS
//  C_AXI_ADDR_WIDTH  32            AXI address width; only addr[7:2] decoded, upper bits ignored (aliasing allowed)
//  NUM_SCRATCH       8             scratch registers at 0x20..0x3C (1..8)
//  ID_VALUE          32'h4E544458  value returned at 0x00
//  VERSION_VALUE     32'h0001_0000 value returned at 0x04
// PORTS
//  clk_i           in   1   clock (same as bridge/CPU clock)
//  rst_i           in   1   synchronous reset, active-high
//  s_axi_awaddr    in   AW  write address;   s_axi_awprot in 3 (ignored)
//  s_axi_awvalid   in   1 / s_axi_awready out 1
//  s_axi_wdata     in   32  write data;      s_axi_wstrb  in 4 byte enables
//  s_axi_wvalid    in   1 / s_axi_wready  out 1
//  s_axi_bresp     out  2 / s_axi_bvalid  out 1 / s_axi_bready in 1
//  s_axi_araddr    in   AW  read address;    s_axi_arprot in 3 (ignored)
//  s_axi_arvalid   in   1 / s_axi_arready out 1
//  s_axi_rdata     out  32 / s_axi_rresp  out 2 / s_axi_rvalid out 1 / s_axi_rready in 1
// BEHAVIOUR
//  Reset: all flags, registers, counters = 0; bvalid=rvalid=0; awready=wready=arready=1 the cycle after.
//  Register map (word offsets): 0x00 ID RO; 0x04 VERSION RO; 0x08 CTRL RW [0]=cnt_en, [1]=cnt_clr
//   (self-clearing, reads 0); 0x0C STATUS RO [15:0]=wr_count, [31:16]=rd_count; 0x10 CNT_LO RO;
//   0x14 CNT_HI RO (shadow); 0x20+4*i SCRATCH[i] RW. Anything else unmapped.
//  Write path: AW and W captured independently into hold regs; awready=!aw_held, wready=!w_held.
//   Commit on edge where aw_held & w_held & !bvalid: clear both held flags, set bvalid, apply write.
//   Min latency: handshake at edge N -> bvalid high after edge N+1. bvalid held until bready.
//   Strobes: only bytes with wstrb=1 updated; wstrb=0 is a legal no-op with OKAY.
//   Write to RO or unmapped -> bresp SLVERR (2'b10), no state change; otherwise OKAY (2'b00).
//  Read path: arready=!rvalid. Handshake at edge N -> rdata/rresp registered, rvalid high after N.
//   rvalid/rdata stable until rready. Unmapped -> SLVERR, rdata 32'hDEAD_BEEF.
//   Read of CNT_LO returns counter[31:0] and loads shadow <= counter[63:32] at same edge.
//  Counter: 64-bit; cnt_clr write zeroes it (priority over increment); else +1 per cycle when
//   cnt_en; wraps 2^64-1 -> 0.
//  wr_count/rd_count: +1 per committed write/read (any resp), saturate at 16'hFFFF.
//  Simultaneous read commit and write commit to same register: read returns pre-write value.
//  Simultaneous STATUS read and count increment: read returns pre-increment value.
//  rst_i mid-transaction: in-flight transaction dropped, no response issued.
// STRUCTURE
//  Package axil_test_device_pkg: register offsets, RESP_OKAY/RESP_SLVERR, UNMAPPED_DATA, CTRL bit idx.
//  Sub-module axil_hold_reg (valid/ready single-entry hold, WIDTH param) used for AW (addr) and
//  W (data+strb); decode, register file, counters and response logic stay in this module.
// TESTING
//  1 Reset, read 0x00 and 0x04 -> rdata 4E544458 / 00010000, rresp OKAY, rvalid 1 cycle after AR hs.
//  2 W before AW (W at cycle 0, AW at cycle 3) to 0x20 data A5A5A5A5 strb F -> single bvalid OKAY;
//    read 0x20 -> A5A5A5A5. Then strb 4'b0010 data 00003C00 -> read A5A53CA5.
//  3 bready held low 10 cycles -> bvalid/bresp stable, awready/wready drop once hold regs full,
//    no second commit; release -> next queued write commits.
//  4 Write 0x04 and read 0x40 -> bresp SLVERR, VERSION unchanged; rresp SLVERR, rdata DEADBEEF.
//  5 CTRL=1, wait 100 cycles, read CNT_LO then CNT_HI -> ~100 / 0; force counter to
//    FFFFFFFF_FFFFFFFE -> wraps to 0; CTRL write 3 -> counter 0, cnt_clr reads back 0.
//  6 rst_i asserted while bvalid=1 and rvalid=1 -> both 0 next cycle, SCRATCH and STATUS read 0.

Source files
------------

// File: rtl/axil_test_device_pkg.sv
// Shared definitions for the AXI4-Lite test device: register word indices
// (address bits [7:2]), response codes, the unmapped read pattern, CTRL bit
// positions, a register-kind decode and a byte-strobe merge helper.
package axil_test_device_pkg;

  localparam logic [5:0] REG_ID       = 6'h00;  // 0x00
  localparam logic [5:0] REG_VERSION  = 6'h01;  // 0x04
  localparam logic [5:0] REG_CTRL     = 6'h02;  // 0x08
  localparam logic [5:0] REG_STATUS   = 6'h03;  // 0x0C
  localparam logic [5:0] REG_CNT_LO   = 6'h04;  // 0x10
  localparam logic [5:0] REG_CNT_HI   = 6'h05;  // 0x14
  localparam logic [5:0] REG_SCRATCH0 = 6'h08;  // 0x20

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

  localparam int unsigned CTRL_CNT_EN  = 0;
  localparam int unsigned CTRL_CNT_CLR = 1;

  typedef enum logic [2:0] {
    RK_ID,
    RK_VERSION,
    RK_CTRL,
    RK_STATUS,
    RK_CNT_LO,
    RK_CNT_HI,
    RK_SCRATCH,
    RK_UNMAPPED
  } reg_kind_e;

  function automatic reg_kind_e decode_reg(input logic [5:0] idx,
                                           input int unsigned num_scratch);
    reg_kind_e k;
    case (idx)
      REG_ID:      k = RK_ID;
      REG_VERSION: k = RK_VERSION;
      REG_CTRL:    k = RK_CTRL;
      REG_STATUS:  k = RK_STATUS;
      REG_CNT_LO:  k = RK_CNT_LO;
      REG_CNT_HI:  k = RK_CNT_HI;
      default: begin
        if (({26'd0, idx} >= 32'(REG_SCRATCH0)) &&
            ({26'd0, idx} < (32'(REG_SCRATCH0) + num_scratch)))
          k = RK_SCRATCH;
        else
          k = RK_UNMAPPED;
      end
    endcase
    return k;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axil_test_device_hold.sv
// axil_hold_reg: single-entry valid/ready holding register.
// Accepts one beat while empty (o_ready = !o_held) and keeps it until the
// consumer pulses i_consume.
//  clk_i, rst_i  clock, synchronous active-high reset
//  i_valid       producer valid;  i_data  payload (WIDTH bits)
//  i_consume     drop the held entry at this edge
//  o_ready       entry empty;     o_held  entry full;  o_data  held payload
module axil_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_consume,
  output logic             o_ready,
  output logic             o_held,
  output logic [WIDTH-1:0] o_data
);

  logic             r_held;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_held <= 1'b0;
      r_data <= '0;
    end else if (!r_held) begin
      if (i_valid) begin
        r_held <= 1'b1;
        r_data <= i_data;
      end
    end else if (i_consume) begin
      r_held <= 1'b0;
    end
  end

  assign o_ready = !r_held;
  assign o_held  = r_held;
  assign o_data  = r_data;

endmodule

// File: rtl/axil_test_device.sv
// axil_test_device: AXI4-Lite slave exposing ID/VERSION, CTRL, STATUS
// (write/read transaction counts), a 64-bit free-running cycle counter with
// a high-word shadow, and scratch registers. Only addr[7:2] is decoded.
//  clk_i, rst_i                  clock, synchronous active-high reset
//  s_axi_aw*/w*/b*               write address, data and response channels
//  s_axi_ar*/r*                  read address and data channels
//  awprot/arprot are accepted and ignored.
module axil_test_device
  import axil_test_device_pkg::*;
#(
  parameter int unsigned C_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_SCRATCH      = 8,
  parameter logic [31:0] ID_VALUE         = 32'h4E544458,
  parameter logic [31:0] VERSION_VALUE    = 32'h0001_0000
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]                  s_axi_awprot,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [31:0]                 s_axi_wdata,
  input  logic [3:0]                  s_axi_wstrb,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  output logic [1:0]                  s_axi_bresp,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]                  s_axi_arprot,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [31:0]                 s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready
);

  logic        w_aw_held, w_w_held, w_commit;
  logic [5:0]  w_aw_idx;
  logic [35:0] w_w_data;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  reg_kind_e   w_wkind, w_rkind;
  logic        w_wr_ok, w_rd_hs, w_clr;
  logic [5:0]  w_ar_idx;
  logic [31:0] w_rdata;
  logic [1:0]  w_rresp;
  logic        w_unused;

  logic        r_bvalid, r_rvalid;
  logic [1:0]  r_bresp, r_rresp;
  logic [31:0] r_rdata;
  logic        r_cnt_en;
  logic [63:0] r_cnt;
  logic [31:0] r_shadow;
  logic [15:0] r_wr_count, r_rd_count;
  logic [31:0] r_scratch [8];

  assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

  axil_hold_reg #(.WIDTH(6)) u_aw_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_valid   (s_axi_awvalid),
    .i_data    (s_axi_awaddr[7:2]),
    .i_consume (w_commit),
    .o_ready   (s_axi_awready),
    .o_held    (w_aw_held),
    .o_data    (w_aw_idx)
  );

  axil_hold_reg #(.WIDTH(36)) u_w_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_valid   (s_axi_wvalid),
    .i_data    ({s_axi_wstrb, s_axi_wdata}),
    .i_consume (w_commit),
    .o_ready   (s_axi_wready),
    .o_held    (w_w_held),
    .o_data    (w_w_data)
  );

  // ---------------- write side ----------------
  assign w_wdata  = w_w_data[31:0];
  assign w_wstrb  = w_w_data[35:32];
  assign w_commit = w_aw_held && w_w_held && !r_bvalid;
  assign w_wkind  = decode_reg(w_aw_idx, NUM_SCRATCH);
  assign w_wr_ok  = (w_wkind == RK_CTRL) || (w_wkind == RK_SCRATCH);
  // cnt_clr is a pulse taken straight from the committed write data.
  assign w_clr    = w_commit && (w_wkind == RK_CTRL) &&
                    w_wstrb[0] && w_wdata[CTRL_CNT_CLR];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_bvalid && s_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt_en <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) r_scratch[i] <= '0;
    end else if (w_commit) begin
      if ((w_wkind == RK_CTRL) && w_wstrb[0])
        r_cnt_en <= w_wdata[CTRL_CNT_EN];
      if (w_wkind == RK_SCRATCH)
        r_scratch[w_aw_idx[2:0]] <= apply_strb(r_scratch[w_aw_idx[2:0]], w_wdata, w_wstrb);
    end
  end

  // ---------------- read side ----------------
  assign w_ar_idx = s_axi_araddr[7:2];
  assign w_rkind  = decode_reg(w_ar_idx, NUM_SCRATCH);
  assign w_rd_hs  = s_axi_arvalid && !r_rvalid;

  // Read mux is built from current register state, so a read committing on
  // the same edge as a write or count update returns the pre-update value.
  always_comb begin
    w_rdata = UNMAPPED_DATA;
    w_rresp = RESP_OKAY;
    case (w_rkind)
      RK_ID:      w_rdata = ID_VALUE;
      RK_VERSION: w_rdata = VERSION_VALUE;
      RK_CTRL:    w_rdata = {31'd0, r_cnt_en};
      RK_STATUS:  w_rdata = {r_rd_count, r_wr_count};
      RK_CNT_LO:  w_rdata = r_cnt[31:0];
      RK_CNT_HI:  w_rdata = r_shadow;
      RK_SCRATCH: w_rdata = r_scratch[w_ar_idx[2:0]];
      default:    w_rresp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_rd_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rresp;
    end else if (r_rvalid && s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      if (w_clr)         r_cnt <= '0;
      else if (r_cnt_en) r_cnt <= r_cnt + 64'd1;
      if (w_rd_hs && (w_rkind == RK_CNT_LO))
        r_shadow <= r_cnt[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      if (w_commit && (r_wr_count != '1)) r_wr_count <= r_wr_count + 16'd1;
      if (w_rd_hs  && (r_rd_count != '1)) r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = !r_rvalid;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;

endmodule

// File: tb/tb_axil_test_device.sv
module tb_axil_test_device;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_test_device #(
    .C_AXI_ADDR_WIDTH (32),
    .NUM_SCRATCH      (8),
    .ID_VALUE         (32'h4E544458),
    .VERSION_VALUE    (32'h0001_0000)
  ) dut (
    .clk_i (clk), .rst_i (rst),
    .s_axi_awaddr (awaddr), .s_axi_awprot (awprot), .s_axi_awvalid (awvalid), .s_axi_awready (awready),
    .s_axi_wdata (wdata), .s_axi_wstrb (wstrb), .s_axi_wvalid (wvalid), .s_axi_wready (wready),
    .s_axi_bresp (bresp), .s_axi_bvalid (bvalid), .s_axi_bready (bready),
    .s_axi_araddr (araddr), .s_axi_arprot (arprot), .s_axi_arvalid (arvalid), .s_axi_arready (arready),
    .s_axi_rdata (rdata), .s_axi_rresp (rresp), .s_axi_rvalid (rvalid), .s_axi_rready (rready)
  );

  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out, got no handshake expected one", name);
  endtask

  // Returns the edge index at which the write committed (bvalid first seen).
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int commit_cyc);
    bit aw_done, w_done;
    int n;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done  = 1;
      @(posedge clk);
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bvalid) timeout("write_b");
    resp = bresp;
    commit_cyc = cyc;
    @(negedge clk);
  endtask

  // Returns the edge index at which AR handshook.
  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output int hs_cyc);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) timeout("read_ar");
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    hs_cyc = cyc;
    check("rvalid_after_ar", 64'(rvalid), 64'd1);
    d = rdata;
    resp = rresp;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[17];

  // Reference model state for the random phase.
  logic [31:0] m_scr [8];
  int          m_wr, m_rd;

  function automatic logic [31:0] model_read(input int idx, output logic [1:0] resp);
    resp = OK;
    if (idx == 0) return 32'h4E544458;
    if (idx == 1) return 32'h0001_0000;
    if (idx == 2) return 32'd0;
    if (idx == 3) return {16'(m_rd), 16'(m_wr)};
    if (idx == 4 || idx == 5) return 32'd0;
    if (idx >= 8 && idx < 16) return m_scr[idx - 8];
    resp = ERR;
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          e, e2, rc, f, idx;
    logic [63:0] exp64;
    bit          stable;

    tbl[0]  = '{0, 32'h000, 32'h0,         4'h0, OK,  32'h4E544458};
    tbl[1]  = '{0, 32'h004, 32'h0,         4'h0, OK,  32'h00010000};
    tbl[2]  = '{1, 32'h004, 32'hFFFFFFFF,  4'hF, ERR, 32'h0};
    tbl[3]  = '{0, 32'h004, 32'h0,         4'h0, OK,  32'h00010000};
    tbl[4]  = '{0, 32'h040, 32'h0,         4'h0, ERR, 32'hDEADBEEF};
    tbl[5]  = '{1, 32'h040, 32'h11111111,  4'hF, ERR, 32'h0};
    tbl[6]  = '{1, 32'h00C, 32'h22222222,  4'hF, ERR, 32'h0};
    tbl[7]  = '{1, 32'h03C, 32'h12345678,  4'hF, OK,  32'h0};
    tbl[8]  = '{0, 32'h03C, 32'h0,         4'h0, OK,  32'h12345678};
    tbl[9]  = '{1, 32'h03C, 32'hAAAAAAAA,  4'h0, OK,  32'h0};
    tbl[10] = '{0, 32'h03C, 32'h0,         4'h0, OK,  32'h12345678};
    tbl[11] = '{1, 32'h03C, 32'h0000FF00,  4'h3, OK,  32'h0};
    tbl[12] = '{0, 32'h13C, 32'h0,         4'h0, OK,  32'h1234FF00};
    tbl[13] = '{0, 32'h018, 32'h0,         4'h0, ERR, 32'hDEADBEEF};
    tbl[14] = '{0, 32'h008, 32'h0,         4'h0, OK,  32'h0};
    tbl[15] = '{0, 32'h00C, 32'h0,         4'h0, OK,  32'h00090006};
    tbl[16] = '{1, 32'h010, 32'h33333333,  4'hF, ERR, 32'h0};

    // Reset
    repeat (3) @(negedge clk);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'({awready, wready, arready}), 64'h7);

    // Table-driven register map / response checks
    for (int i = 0; i < 17; i++) begin
      if (tbl[i].is_wr) begin
        axi_write(tbl[i].addr, tbl[i].wd, tbl[i].strb, r, e);
        check($sformatf("tbl%0d_bresp", i), 64'(r), 64'(tbl[i].exp_resp));
      end else begin
        axi_read(tbl[i].addr, d, r, rc);
        check($sformatf("tbl%0d_rresp", i), 64'(r), 64'(tbl[i].exp_resp));
        check($sformatf("tbl%0d_rdata", i), 64'(d), 64'(tbl[i].exp_rdata));
      end
    end

    // W three cycles before AW
    @(negedge clk);
    wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1'b1; awaddr = 32'h20;
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0;
    check("wfirst_wready_low", 64'(wready), 64'd0);
    repeat (2) @(negedge clk);
    check("wfirst_no_commit", 64'(bvalid), 64'd0);
    awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    @(negedge clk);
    check("wfirst_bvalid", 64'({bvalid, bresp}), 64'({1'b1, OK}));
    @(negedge clk);
    check("wfirst_single_b", 64'(bvalid), 64'd0);
    axi_read(32'h20, d, r, rc);
    check("wfirst_rd", 64'(d), 64'hA5A5A5A5);
    axi_write(32'h20, 32'h00003C00, 4'b0010, r, e);
    axi_read(32'h20, d, r, rc);
    check("strb_rd", 64'(d), 64'hA5A53CA5);

    // B back-pressure with a second write queued in the hold registers
    bready = 1'b0;
    @(negedge clk);
    awaddr = 32'h24; wdata = 32'h0BAD_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bp_bvalid", 64'(bvalid), 64'd1);
    awaddr = 32'h28; wdata = 32'h600D_CAFE; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bp_ready_low", 64'({awready, wready}), 64'd0);
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(bvalid === 1'b1 && bresp === OK && awready === 1'b0 && wready === 1'b0)) stable = 0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    bready = 1'b1;
    @(negedge clk);
    check("bp_release_drop", 64'(bvalid), 64'd0);
    @(negedge clk);
    check("bp_second_commit", 64'(bvalid), 64'd1);
    @(negedge clk);
    axi_read(32'h24, d, r, rc);
    check("bp_rd1", 64'(d), 64'h0BADF00D);
    axi_read(32'h28, d, r, rc);
    check("bp_rd2", 64'(d), 64'h600DCAFE);

    // Cycle counter
    axi_write(32'h08, 32'h1, 4'hF, r, e);
    repeat (100) @(negedge clk);
    axi_read(32'h10, d, r, rc);
    check("cnt_lo", 64'(d), 64'(rc - e - 1));
    axi_read(32'h14, d, r, rc);
    check("cnt_hi", 64'(d), 64'd0);
    @(negedge clk);
    force dut.r_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
    f = cyc;
    #1 release dut.r_cnt;
    repeat (3) @(negedge clk);
    axi_read(32'h10, d, r, rc);
    exp64 = 64'hFFFF_FFFF_FFFF_FFFE + 64'(rc - 1 - f);
    check("cnt_wrap_lo", 64'(d), 64'(exp64[31:0]));
    axi_read(32'h14, d, r, rc);
    check("cnt_wrap_hi", 64'(d), 64'(exp64[63:32]));
    axi_write(32'h08, 32'h3, 4'hF, r, e2);
    axi_read(32'h10, d, r, rc);
    check("cnt_clr", 64'(d), 64'(rc - e2 - 1));
    axi_read(32'h08, d, r, rc);
    check("ctrl_readback", 64'(d), 64'd1);

    // Reset while both responses are pending
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    awaddr = 32'h20; wdata = 32'h5555_5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h08; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_valids", 64'({bvalid, rvalid}), 64'h3);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid_rst_valids", 64'({bvalid, rvalid}), 64'h0);
    rst = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    axi_read(32'h0C, d, r, rc);
    check("post_rst_status", 64'(d), 64'd0);
    axi_read(32'h20, d, r, rc);
    check("post_rst_scratch", 64'(d), 64'd0);
    axi_read(32'h10, d, r, rc);
    check("post_rst_cnt", 64'(d), 64'd0);

    // Random traffic against the reference model (counter left disabled)
    for (int i = 0; i < 8; i++) m_scr[i] = '0;
    m_wr = 0; m_rd = 3;
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a, wd, exp_d;
      logic [3:0]  s;
      logic [1:0]  exp_r;
      idx = ($urandom_range(0, 2) != 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 63));
      a   = ($urandom() & 32'hFFFF_FF00) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        if (idx == 2) begin
          idx = 9;
          a = 32'h24;
        end
        wd = $urandom();
        s  = 4'($urandom_range(0, 15));
        axi_write(a, wd, s, r, e);
        exp_r = ERR;
        if (idx >= 8 && idx < 16) begin
          exp_r = OK;
          for (int b = 0; b < 4; b++)
            if (s[b]) m_scr[idx - 8][8*b +: 8] = wd[8*b +: 8];
        end
        m_wr++;
        check($sformatf("rnd%0d_bresp", t), 64'(r), 64'(exp_r));
      end else begin
        exp_d = model_read(idx, exp_r);
        axi_read(a, d, r, rc);
        m_rd++;
        check($sformatf("rnd%0d_rresp", t), 64'(r), 64'(exp_r));
        check($sformatf("rnd%0d_rdata", t), 64'(d), 64'(exp_d));
      end
    end
    axi_read(32'h0C, d, r, rc);
    check("rnd_status", 64'(d), 64'({16'(m_rd), 16'(m_wr)}));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
